// File: rtl/sim_bus_pkg.sv
// Shared types and constants for the simulator bus adapter: FSM states,
// default timeout data, LFSR seed/taps and the error-data width fit helper.
package sim_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int unsigned ERR_MAX_W     = 256;
    localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bits 15,13,12,10 correspond to the polynomial taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

    function automatic logic [ERR_MAX_W-1:0] err_fit(input logic [ERR_MAX_W-1:0] v,
                                                     input int unsigned           w);
        logic [ERR_MAX_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < ERR_MAX_W; i++) begin
            if (i < w) mask[i] = 1'b1;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/sim_bus_sat_counter.sv
// Statistics counter that either wraps or sticks at all-ones, selected by SATURATE.
module sim_bus_sat_counter #(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c);
        if (SATURATE && (&c)) return c;
        return c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= next_count(count_q);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sim_bus_adapter.sv
// Registered bridge from a bus_if master to the simulator memory port with wait-state
// injection, response timeout and statistics. Define SIM_BUS_LAT_RANDOM_EN for LFSR waits.
module sim_bus_adapter
    import sim_bus_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 19,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          WAIT_W   = 4,
    parameter int unsigned          TIMEOUT  = 256,
    parameter logic [ERR_MAX_W-1:0] ERR_DATA = ERR_MAX_W'(ERR_DATA_DFLT),
    parameter int unsigned          CNT_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m_valid_i,
    input  logic [ADDR_W-1:0]     m_addr_i,
    input  logic [DATA_W-1:0]     m_wdata_i,
    input  logic [DATA_W/8-1:0]   m_wstrb_i,
    input  logic                  m_instr_i,
    output logic                  m_ready_o,
    output logic [DATA_W-1:0]     m_rdata_o,
    output logic                  s_valid_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic [DATA_W/8-1:0]   s_wstrb_o,
    output logic                  s_instr_o,
    input  logic                  s_ready_i,
    input  logic [DATA_W-1:0]     s_rdata_i,
    input  logic [WAIT_W-1:0]     wait_states_i,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      cycles_o,
    output logic [CNT_W-1:0]      rd_count_o,
    output logic [CNT_W-1:0]      wr_count_o
);

    localparam int unsigned       STRB_W  = DATA_W / 8;
    localparam int unsigned       TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_MAX  = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [DATA_W-1:0] ERR_FIT = DATA_W'(err_fit(ERR_DATA, DATA_W));

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                instr_q;
    logic [WAIT_W-1:0]   wcnt_q;
    logic [TO_W-1:0]     tcnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                timeout_q;
    logic [WAIT_W-1:0]   w_sel;
    logic                accept, hit, expire, enter_resp;

`ifdef SIM_BUS_LAT_RANDOM_EN
    logic [15:0] lfsr_q;

    // wait_states_i masks the pseudo-random latency drawn for this request
    assign w_sel = lfsr_q[WAIT_W-1:0] & wait_states_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end
`else
    assign w_sel = wait_states_i;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hit     = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_valid_i) begin
                    accept  = 1'b1;
                    state_d = (w_sel != '0) ? WAIT : REQ;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) state_d = REQ;
            end
            REQ: begin
                // A ready on the final allowed cycle beats the timeout
                if (s_ready_i) begin
                    hit     = 1'b1;
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (tcnt_q == TO_MAX)) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = hit | expire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= m_addr_i;
                wdata_q <= m_wdata_i;
                wstrb_q <= m_wstrb_i;
                instr_q <= m_instr_i;
                wcnt_q  <= w_sel - WAIT_W'(1);
            end else if ((state_q == WAIT) && (wcnt_q != '0)) begin
                wcnt_q <= wcnt_q - WAIT_W'(1);
            end
            if (state_q != REQ) begin
                tcnt_q <= '0;
            end else if (!enter_resp) begin
                tcnt_q <= tcnt_q + TO_W'(1);
            end
            if (hit) begin
                rdata_q <= s_rdata_i;
            end else if (expire) begin
                rdata_q   <= ERR_FIT;
                timeout_q <= 1'b1;
            end
        end
    end

    sim_bus_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_cycles (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (1'b1),
        .count_o (cycles_o)
    );

    sim_bus_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_rd_count (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (enter_resp & ~(|wstrb_q)),
        .count_o (rd_count_o)
    );

    sim_bus_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_wr_count (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (enter_resp & (|wstrb_q)),
        .count_o (wr_count_o)
    );

    assign m_ready_o = (state_q == RESP);
    assign m_rdata_o = rdata_q;
    assign s_valid_o = (state_q == REQ);
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
    assign s_wstrb_o = wstrb_q;
    assign s_instr_o = instr_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sim_bus_adapter.sv
// Directed bench for sim_bus_adapter (TIMEOUT=8); follows the LFSR wait model when
// SIM_BUS_LAT_RANDOM_EN is defined.
module tb_sim_bus_adapter;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 32;
    localparam int WAIT_W  = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                m_valid = 1'b0;
    logic [ADDR_W-1:0]   m_addr = '0;
    logic [DATA_W-1:0]   m_wdata = '0;
    logic [DATA_W/8-1:0] m_wstrb = '0;
    logic                m_instr = 1'b0;
    logic                m_ready;
    logic [DATA_W-1:0]   m_rdata;
    logic                s_valid;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_instr;
    logic                s_ready = 1'b0;
    logic [DATA_W-1:0]   s_rdata = '0;
    logic [WAIT_W-1:0]   wait_states = '0;
    logic                busy;
    logic                timeout;
    logic [CNT_W-1:0]    cycles;
    logic [CNT_W-1:0]    rd_count;
    logic [CNT_W-1:0]    wr_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    always #5 clk = ~clk;

    sim_bus_adapter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .m_valid_i     (m_valid),
        .m_addr_i      (m_addr),
        .m_wdata_i     (m_wdata),
        .m_wstrb_i     (m_wstrb),
        .m_instr_i     (m_instr),
        .m_ready_o     (m_ready),
        .m_rdata_o     (m_rdata),
        .s_valid_o     (s_valid),
        .s_addr_o      (s_addr),
        .s_wdata_o     (s_wdata),
        .s_wstrb_o     (s_wstrb),
        .s_instr_o     (s_instr),
        .s_ready_i     (s_ready),
        .s_rdata_i     (s_rdata),
        .wait_states_i (wait_states),
        .busy_o        (busy),
        .timeout_o     (timeout),
        .cycles_o      (cycles),
        .rd_count_o    (rd_count),
        .wr_count_o    (wr_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_w(input logic [WAIT_W-1:0] ws);
`ifdef SIM_BUS_LAT_RANDOM_EN
        return int'(lfsr_m[WAIT_W-1:0] & ws);
`else
        return int'(ws);
`endif
    endfunction

    task automatic adv_lfsr();
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    endtask

    // ready_at: REQ cycle index (0-based) on which s_ready is raised; -1 never
    task automatic xact(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [3:0] st, input logic ins,
                        input logic [WAIT_W-1:0] ws, input logic [WAIT_W-1:0] ws_mid,
                        input int ready_at, input logic [DATA_W-1:0] rd);
        int w;
        int n;
        logic [DATA_W-1:0] exp_data;
        wait_states = ws;
        m_valid = 1'b1;
        m_addr  = a;
        m_wdata = wd;
        m_wstrb = st;
        m_instr = ins;
        w = model_w(ws);
        adv_lfsr();
        step();
        wait_states = ws_mid;
        for (int i = 0; i < w; i++) begin
            chk({tag, ".wait_svalid"}, 64'(s_valid), 64'd0);
            step();
        end
        chk({tag, ".req_svalid"}, 64'(s_valid), 64'd1);
        chk({tag, ".s_addr"}, 64'(s_addr), 64'(a));
        chk({tag, ".s_wstrb"}, 64'(s_wstrb), 64'(st));
        chk({tag, ".s_wdata"}, 64'(s_wdata), 64'(wd));
        chk({tag, ".s_instr"}, 64'(s_instr), 64'(ins));
        n = (ready_at >= 0 && ready_at < TIMEOUT) ? ready_at + 1 : TIMEOUT;
        for (int i = 0; i < n; i++) begin
            s_ready = (i == ready_at);
            s_rdata = rd;
            chk({tag, ".req_hold"}, 64'({s_valid, m_ready}), 64'b10);
            step();
        end
        s_ready  = 1'b0;
        exp_data = (n == ready_at + 1) ? rd : 32'hDEAD_BEEF;
        if (st != 4'b0000) exp_wr++;
        else exp_rd++;
        chk({tag, ".m_ready"}, 64'(m_ready), 64'd1);
        chk({tag, ".m_rdata"}, 64'(m_rdata), 64'(exp_data));
        chk({tag, ".resp_svalid"}, 64'(s_valid), 64'd0);
        chk({tag, ".rd_count"}, 64'(rd_count), 64'(exp_rd));
        chk({tag, ".wr_count"}, 64'(wr_count), 64'(exp_wr));
        m_valid = 1'b0;
        step();
        chk({tag, ".ready_pulse"}, 64'(m_ready), 64'd0);
        chk({tag, ".rdata_hold"}, 64'(m_rdata), 64'(exp_data));
        chk({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".s_valid"}, 64'(s_valid), 64'd0);
        chk({tag, ".m_ready"}, 64'(m_ready), 64'd0);
        chk({tag, ".m_rdata"}, 64'(m_rdata), 64'd0);
        chk({tag, ".s_addr"}, 64'(s_addr), 64'd0);
        chk({tag, ".s_wstrb"}, 64'(s_wstrb), 64'd0);
        chk({tag, ".timeout"}, 64'(timeout), 64'd0);
        chk({tag, ".cycles"}, 64'(cycles), 64'd0);
        chk({tag, ".rd_count"}, 64'(rd_count), 64'd0);
        chk({tag, ".wr_count"}, 64'(wr_count), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("reset");
        step();
        rst_n = 1'b1;
        chk("reset.cycles_start", 64'(cycles), 64'd0);
        step();
        chk("reset.cycles_one", 64'(cycles), 64'd1);
        step();

        xact("rd_w0", 19'h00100, 32'h0, 4'b0000, 1'b0, 4'd0, 4'd0, 0, 32'h1234_5678);
        xact("wr_w3", 19'h00200, 32'hA5A5_5A5A, 4'b0101, 1'b0, 4'd3, 4'd3, 0, 32'h0);
        xact("rdy_last", 19'h00300, 32'h0, 4'b0000, 1'b1, 4'd0, 4'd0, 7, 32'hCAFE_F00D);
        chk("rdy_last.timeout", 64'(timeout), 64'd0);
        xact("timeout", 19'h7FFFF, 32'h0, 4'b0000, 1'b0, 4'd1, 4'd1, -1, 32'h1111_2222);
        chk("timeout.flag", 64'(timeout), 64'd1);
        xact("sticky", 19'h00004, 32'h0BAD_CAFE, 4'b1111, 1'b0, 4'd0, 4'd0, 2, 32'h0);
        chk("sticky.flag", 64'(timeout), 64'd1);
        xact("ws_2to7", 19'h00010, 32'h0, 4'b0000, 1'b0, 4'd2, 4'd7, 0, 32'h0000_0002);
        xact("ws_7", 19'h00020, 32'h0, 4'b0000, 1'b0, 4'd7, 4'd7, 1, 32'h0000_0007);
        xact("ws_max", 19'h00030, 32'h0, 4'b1000, 1'b1, 4'd15, 4'd15, 0, 32'h0);

        // Reset while the request sits in WAIT
        wait_states = 4'd5;
        m_valid = 1'b1;
        m_addr  = 19'h00555;
        m_wstrb = 4'b0011;
        adv_lfsr();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("rst_wait");
        m_valid = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        lfsr_m  = 16'hACE1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_wait.no_ready", 64'(m_ready), 64'd0);
            step();
        end
        chk("rst_wait.cycles", 64'(cycles), 64'd4);
        chk("rst_wait.idle", 64'(busy), 64'd0);

        xact("post_rst", 19'h00100, 32'h0, 4'b0000, 1'b0, 4'd2, 4'd2, 0, 32'h8765_4321);
        chk("post_rst.timeout", 64'(timeout), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/sim_bus_adapter.md
Name: sim_bus_adapter

Overview:
- Parametrised, registered bridge between one tta bus_if master port and a flat simulator memory-model port; the sim top instantiates one per bus (instr, data).
- Adds programmable wait-state injection, a response timeout with error data, and transaction/cycle statistics with correct reset behaviour.
- Widths and timing are generic, so the same block serves wider addresses, wider data and both channels.

Parameters:
ADDR_W, 19, address width
DATA_W, 32, data width; byte strobes are DATA_W/8
WAIT_W, 4, width of the wait-state count
TIMEOUT, 256, maximum REQ cycles before error completion; 0 disables the timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout, zero-extended or truncated to DATA_W
CNT_W, 32, statistics counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
m_valid_i  in  1  master request
m_addr_i  in  ADDR_W  master address
m_wdata_i  in  DATA_W  master write data
m_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read
m_instr_i  in  1  instruction-fetch tag
m_ready_o  out  1  one-cycle completion pulse
m_rdata_o  out  DATA_W  read data, valid while m_ready_o is high
s_valid_o  out  1  simulator request
s_addr_o  out  ADDR_W  simulator address
s_wdata_o  out  DATA_W  simulator write data
s_wstrb_o  out  DATA_W/8  simulator byte strobes
s_instr_o  out  1  instruction-fetch tag
s_ready_i  in  1  simulator completion
s_rdata_i  in  DATA_W  simulator read data
wait_states_i  in  WAIT_W  injected wait cycles per request
busy_o  out  1  high whenever the state is not IDLE
timeout_o  out  1  sticky flag: a timeout has occurred
cycles_o  out  CNT_W  cycles since reset
rd_count_o  out  CNT_W  completed reads
wr_count_o  out  CNT_W  completed writes

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state goes to IDLE.
  - All outputs, counters and captured request fields are cleared to 0.
  - Reset mid-transaction abandons the transaction; no m_ready_o pulse is produced.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- State machine:
  - IDLE: m_valid_i sampled high at edge N:
    - latch addr, wdata, wstrb and instr;
    - latch W = wait_states_i (the value at that edge is used; later changes do not affect this request);
    - go to WAIT if W > 0, otherwise go to REQ.
  - WAIT: count down W cycles, then go to REQ. REQ is entered at edge N+W.
  - REQ:
    - s_valid_o = 1 and the s_* outputs carry the latched fields.
    - s_ready_i sampled high: capture s_rdata_i and go to RESP.
    - Otherwise, once TIMEOUT REQ cycles have elapsed (TIMEOUT > 0): m_rdata_o = ERR_DATA, set timeout_o, go to RESP.
    - s_ready_i high on the timeout edge: ready wins and no timeout is flagged.
  - RESP:
    - m_ready_o = 1 for exactly one cycle; go to IDLE.
    - m_rdata_o holds its value until the next RESP.
- Latency: with s_ready_i high on the first REQ cycle, m_ready_o is high W+1 cycles after m_valid_i is first sampled.
- Master rule: m_valid_i is dropped on the edge at which m_ready_o is seen. IDLE never re-accepts in the RESP cycle, so back-to-back requests are spaced at least W+2 cycles apart.
- Statistics:
  - cycles_o: +1 every cycle after reset; wraps modulo 2^CNT_W.
  - rd_count_o / wr_count_o: +1 on entry to RESP for a read or write respectively (write = any wstrb bit set). Timed-out transactions also count.
  - rd_count_o / wr_count_o saturate at all-ones.
- W at its maximum value (2^WAIT_W - 1) is legal.

Optional Feature:
SIM_BUS_LAT_RANDOM_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances once per accepted request.
  - W = lfsr[WAIT_W-1:0] & wait_states_i, so wait_states_i acts as a mask on the maximum.
  - The LFSR is reset asynchronously with everything else.
- Undefined: W = wait_states_i exactly; no LFSR logic is present.

Decomposition:
- Package sim_bus_pkg:
  - state enum (IDLE, WAIT, REQ, RESP);
  - default ERR_DATA and LFSR seed/tap constants;
  - a helper function for the ERR_DATA width fit.
- Sub-module sim_bus_sat_counter (CNT_W, saturating/wrapping select), instantiated three times.
- LFSR stays inline.

Test Plan:
- W=0, read addr 0x00100, s_ready_i high immediately with rdata 0x12345678 -> m_ready_o high exactly 1 cycle after m_valid_i is first sampled, m_rdata_o=0x12345678, rd_count_o=1.
- W=3, write wstrb=4'b0101 -> s_valid_o rises 3 cycles after acceptance with wstrb=0101; m_ready_o is a single pulse; wr_count_o=1, rd_count_o=0.
- TIMEOUT=8, s_ready_i held low -> s_valid_o high for 8 cycles, then m_ready_o with m_rdata_o=0xDEADBEEF, timeout_o=1 and sticky.
- s_ready_i rises on the 8th REQ cycle with TIMEOUT=8 -> normal data returned, timeout_o stays 0.
- rst_ni pulsed low while in WAIT -> outputs are 0 immediately (asynchronous); no m_ready_o pulse afterwards; cycles_o restarts at 0.
- wait_states_i changed from 2 to 7 during WAIT -> the current request still uses W=2; the next request uses W=7. With SIM_BUS_LAT_RANDOM_EN defined, the observed wait sequence matches the LFSR model from seed 0xACE1.
